// File: rtl/waveform_to_pipe_pkg.sv
// Shared definitions for the waveform capture / pipe-out block:
// FSM encoding, default buffer geometry and the half-word selector.
package waveform_to_pipe_pkg;

    localparam int DEPTH_DEFAULT = 1024;
    localparam int AW_DEFAULT    = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Low half goes out first, then the high half of the same sample.
    function automatic logic [15:0] half_sel(input logic [31:0] sample, input logic hi);
        return hi ? sample[31:16] : sample[15:0];
    endfunction

endpackage

// File: rtl/waveform_to_pipe_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module capture_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/waveform_to_pipe.sv
// Captures a burst of 32-bit samples into a buffer and streams them out as
// 16-bit half-words, with drain allowed while capture is still running.
module waveform_to_pipe
    import waveform_to_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sample_valid,
    input  logic [31:0]   sample_data,
    input  logic [AW:0]   n_samples,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic          ep_ready,
    output logic [AW+1:0] words_avail,
    output logic          done,
    output logic          rd_underflow
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          hs_q, hs_d;
    logic [AW+1:0] avail_q, avail_d;
    logic          und_q, und_d;
    logic [15:0]   last_q;
    logic          byp_q;
    logic [31:0]   byp_data_q;
    logic [31:0]   ram_rdata;
    logic [31:0]   cur_sample;
    logic          wr_fire, rd_fire, last_write, not_empty;

    assign wr_ptr     = wr_cnt_q[AW-1:0];
    assign not_empty  = (avail_q != '0);
    assign wr_fire    = (state_q == ST_CAPTURE) && sample_valid && !start;
    assign rd_fire    = rd_en && not_empty && !start;
    assign last_write = wr_fire && ((wr_cnt_q + (AW+1)'(1)) == cnt_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_CAPTURE;
        end else if (last_write) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        done         = (state_q == ST_DONE);
        ep_ready     = not_empty;
        words_avail  = avail_q;
        rd_underflow = und_q;
        rd_data      = not_empty ? half_sel(cur_sample, hs_q) : last_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_ptr_d = rd_ptr_q;
        hs_d     = hs_q;
        avail_d  = avail_q;
        und_d    = und_q;
        if (start) begin
            cnt_d    = ((n_samples == '0) || (n_samples > DEPTH_L)) ? DEPTH_L : n_samples;
            wr_cnt_d = '0;
            rd_ptr_d = '0;
            hs_d     = 1'b0;
            avail_d  = '0;
            und_d    = 1'b0;
        end else begin
            if (rd_en && !not_empty) begin
                und_d = 1'b1;
            end
            if (rd_fire) begin
                hs_d = ~hs_q;
                if (hs_q) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            if (wr_fire) begin
                wr_cnt_d = wr_cnt_q + (AW+1)'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   avail_d = avail_q + (AW+2)'(2);
                2'b11:   avail_d = avail_q + (AW+2)'(1);
                2'b01:   avail_d = avail_q - (AW+2)'(1);
                default: avail_d = avail_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= DEPTH_L;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
            hs_q     <= 1'b0;
            avail_q  <= '0;
            und_q    <= 1'b0;
            last_q   <= '0;
            byp_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_cnt_q <= wr_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            hs_q     <= hs_d;
            avail_q  <= avail_d;
            und_q    <= und_d;
            last_q   <= rd_data;
            byp_q    <= wr_fire && (wr_ptr == rd_ptr_d);
        end
    end

    // The RAM is addressed with the next read pointer so its registered output
    // lines up with rd_ptr_q; a same-edge write to that address is bypassed.
    always_ff @(posedge clk) begin
        byp_data_q <= sample_data;
    end

    assign cur_sample = byp_q ? byp_data_q : ram_rdata;

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (32)
    ) u_capture_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr),
        .wdata_i (sample_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Self-checking bench for waveform_to_pipe: directed scenarios plus a random
// phase, all compared against a queue-based half-word model.
module tb_waveform_to_pipe;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          sample_valid = 1'b0;
    logic [31:0]   sample_data = '0;
    logic [AW:0]   n_samples = '0;
    logic          rd_en = 1'b0;
    logic [15:0]   rd_data;
    logic          ep_ready;
    logic [AW+1:0] words_avail;
    logic          done;
    logic          rd_underflow;

    always #5 clk = ~clk;

    waveform_to_pipe #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .n_samples    (n_samples),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .ep_ready     (ep_ready),
        .words_avail  (words_avail),
        .done         (done),
        .rd_underflow (rd_underflow)
    );

    int errors = 0;
    int checks = 0;

    typedef enum int {M_IDLE, M_CAP, M_DONE} mstate_t;
    mstate_t     m_st = M_IDLE;
    logic [15:0] m_q[$];
    int          m_cnt = DEPTH;
    int          m_wrn = 0;
    logic        m_und = 1'b0;
    logic [15:0] m_shown = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic st, input logic sv, input logic [31:0] d,
                                input logic [AW:0] n, input logic rd);
        if (st) begin
            m_st  = M_CAP;
            m_q.delete();
            m_und = 1'b0;
            m_wrn = 0;
            m_cnt = ((n == 0) || (int'(n) > DEPTH)) ? DEPTH : int'(n);
        end else begin
            if (rd) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_und = 1'b1;
            end
            if (m_st == M_CAP && sv) begin
                m_q.push_back(d[15:0]);
                m_q.push_back(d[31:16]);
                m_wrn++;
                if (m_wrn == m_cnt) m_st = M_DONE;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] exp_rd;
        exp_rd = (m_q.size() > 0) ? m_q[0] : m_shown;
        chk({tag, ".rd_data"},      32'(rd_data),      32'(exp_rd));
        chk({tag, ".words_avail"},  32'(words_avail),  32'(m_q.size()));
        chk({tag, ".ep_ready"},     32'(ep_ready),     32'(m_q.size() > 0));
        chk({tag, ".done"},         32'(done),         32'(m_st == M_DONE));
        chk({tag, ".rd_underflow"}, 32'(rd_underflow), 32'(m_und));
        m_shown = exp_rd;
    endtask

    task automatic cycle(input logic st, input logic sv, input logic [31:0] d,
                         input logic [AW:0] n, input logic rd, input string tag);
        start = st; sample_valid = sv; sample_data = d; n_samples = n; rd_en = rd;
        @(posedge clk);
        model_update(st, sv, d, n, rd);
        #1;
        start = 1'b0; sample_valid = 1'b0; rd_en = 1'b0;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #2;
        m_st = M_IDLE; m_q.delete(); m_und = 1'b0; m_shown = '0;
        check_outputs(tag);
        chk({tag, ".rd_data_zero"}, 32'(rd_data), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] basic_smp [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [15:0] basic_exp [8] = '{16'h0000, 16'h3F80, 16'h0000, 16'h4000,
                                   16'h0000, 16'h4040, 16'h0000, 16'h4080};

    initial begin
        logic [15:0] held;
        #3;
        apply_reset("rst0");

        // Basic capture and drain
        cycle(1, 0, 0, 11'd4, 0, "basic_start");
        for (int i = 0; i < 4; i++) cycle(0, 1, basic_smp[i], 0, 0, "basic_wr");
        chk("basic.done", 32'(done), 32'h1);
        chk("basic.avail8", 32'(words_avail), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("basic.order", 32'(rd_data), 32'(basic_exp[i]));
            cycle(0, 0, 0, 0, 1, "basic_rd");
        end
        chk("basic.empty", 32'(words_avail), 32'h0);

        // Underflow: empty read sets sticky flag, data held, start clears
        held = rd_data;
        cycle(0, 0, 0, 0, 1, "uf_rd");
        chk("uf.flag", 32'(rd_underflow), 32'h1);
        chk("uf.held", 32'(rd_data), 32'(held));
        cycle(0, 0, 0, 0, 0, "uf_stay");
        chk("uf.sticky", 32'(rd_underflow), 32'h1);
        cycle(1, 0, 0, 11'd3, 0, "uf_start");
        chk("uf.cleared", 32'(rd_underflow), 32'h0);

        // Streaming read in the same cycle as a write
        cycle(0, 1, 32'hAAAA5555, 0, 0, "str_wr1");
        chk("str.avail2", 32'(words_avail), 32'd2);
        cycle(0, 1, 32'hCCCC3333, 0, 1, "str_wr_rd");
        chk("str.avail3", 32'(words_avail), 32'd3);
        chk("str.next", 32'(rd_data), 32'hAAAA);
        cycle(0, 1, 32'h12345678, 0, 1, "str_wr_rd2");
        repeat (6) cycle(0, 0, 0, 0, 1, "str_drain");

        // Restart precedence: start beats a simultaneous sample
        cycle(1, 0, 0, 11'd5, 0, "rp_start1");
        cycle(0, 1, 32'h11112222, 0, 0, "rp_wr");
        cycle(0, 1, 32'h33334444, 0, 0, "rp_wr");
        cycle(1, 1, 32'hDEADBEEF, 11'd2, 0, "rp_restart");
        chk("rp.avail0", 32'(words_avail), 32'h0);
        cycle(0, 1, 32'h55556666, 0, 0, "rp_wr2");
        chk("rp.not_done", 32'(done), 32'h0);
        cycle(0, 1, 32'h77778888, 0, 0, "rp_wr2");
        chk("rp.done_at2", 32'(done), 32'h1);
        cycle(0, 1, 32'h9999AAAA, 0, 0, "rp_ignored");
        chk("rp.avail4", 32'(words_avail), 32'd4);

        // Reset mid-capture after three samples
        cycle(1, 0, 0, 11'd8, 0, "rm_start");
        for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, 0, i == 1, "rm_wr");
        apply_reset("rm_reset");
        for (int i = 0; i < 3; i++) cycle(0, 1, $urandom, 0, 0, "rm_ignored");
        chk("rm.avail0", 32'(words_avail), 32'h0);

        // Clamp to DEPTH: n_samples = 0, 1100 strobes
        cycle(1, 0, 0, 11'd0, 0, "cl_start");
        for (int i = 1; i <= 1100; i++) begin
            cycle(0, 1, $urandom, 0, 0, "cl_wr");
            if (i == 1023) chk("cl.not_done_1023", 32'(done), 32'h0);
            if (i == 1024) chk("cl.done_1024", 32'(done), 32'h1);
        end
        chk("cl.avail2048", 32'(words_avail), 32'd2048);
        repeat (2048) cycle(0, 0, 0, 0, 1, "cl_drain");
        chk("cl.done_after_drain", 32'(done), 32'h1);

        // Randomized traffic, including oversized and zero counts
        cycle(1, 0, 0, 11'd6, 0, "rnd_start");
        for (int i = 0; i < 600; i++) begin
            logic        st;
            logic [AW:0] n;
            st = ($urandom_range(0, 49) == 0);
            n  = ($urandom_range(0, 9) == 0) ? AW'(0) + 11'($urandom_range(0, 2047))
                                               : 11'($urandom_range(0, 12));
            cycle(st, 1'($urandom_range(0, 1)), $urandom, n,
                  ($urandom_range(0, 2) != 0), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
